matmul_sp_reader: RTL

- Synthesizable APB requester that drains result matrix C from the matmul scratchpad (SP) once the accelerator goes idle.
- Sits directly downstream of the matmul APB slave. Issues one APB read per SP line and emits each line as a beat on a valid/ready stream.
- Replaces host/bench polling of the SP with a hardware read-back path.

---
 rtl/matmul_sp_reader_if.sv | 26 ++
 rtl/matmul_sp_reader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/matmul_sp_reader_if.sv
// APB bus between the SP reader (requester) and the matmul APB slave.
interface matmul_sp_reader_if #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_DIM    = 4
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [MAX_DIM-1:0]    pstrb;
  logic [BUS_WIDTH-1:0]  pwdata;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [BUS_WIDTH-1:0]  prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, pstrb, pwdata, paddr,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, pstrb, pwdata, paddr,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/matmul_sp_reader.sv
// Drains result matrix C from the matmul scratchpad over APB once the accelerator is idle,
// emitting one SP line per beat on a valid/ready stream.
module matmul_sp_reader #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_DIM    = 4,
  parameter logic [4:0]  SP_ADDR    = 5'b10000,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned LW = $clog2(MAX_DIM),
  localparam int unsigned CW = $clog2(MAX_DIM) + 1,
  localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CW-1:0]        num_lines_i,
  input  logic                 mm_busy_i,
  matmul_sp_reader_if.master   apb,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic [LW-1:0]        line_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [LW-1:0]        err_line_o
);

  typedef enum logic [2:0] {StIdle, StWaitMm, StSetup, StAccess, StPush, StFinish} state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        line_q, line_d;
  logic [LW-1:0]        beat_line_q, beat_line_d;
  logic [LW-1:0]        err_line_q, err_line_d;
  logic [CW-1:0]        num_q, num_d;
  logic [CW-1:0]        num_clamped;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 last_line;
  logic [ADDR_WIDTH-1:0] addr;

  assign num_clamped = (num_lines_i > CW'(MAX_DIM)) ? CW'(MAX_DIM) : num_lines_i;
  assign last_line   = ({1'b0, line_q} + CW'(1)) == num_q;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    beat_line_d = beat_line_q;
    err_line_d  = err_line_q;
    num_d       = num_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d      = num_clamped;
          line_d     = '0;
          err_d      = 1'b0;
          err_code_d = 2'b00;
          err_line_d = '0;
          state_d    = (num_clamped == '0) ? StFinish : StWaitMm;
        end
      end
      StWaitMm: begin
        if (!mm_busy_i) state_d = StSetup;
      end
      StSetup: begin
        tmo_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        tmo_d = tmo_q + TW'(1);
        if (apb.pready) begin
          if (apb.pslverr) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
            err_line_d = line_q;
            state_d    = StFinish;
          end else begin
            data_d      = apb.prdata;
            beat_line_d = line_q;
            state_d     = StPush;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          err_line_d = line_q;
          state_d    = StFinish;
        end
      end
      StPush: begin
        if (ready_i) begin
          if (last_line) begin
            state_d = StFinish;
          end else begin
            line_d  = line_q + LW'(1);
            state_d = StSetup;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      line_q      <= '0;
      beat_line_q <= '0;
      err_line_q  <= '0;
      num_q       <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      beat_line_q <= beat_line_d;
      err_line_q  <= err_line_d;
      num_q       <= num_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    addr             = '0;
    addr[4:0]        = SP_ADDR;
    addr[5 +: LW]    = line_q;
  end

  // Address is forced to zero outside a transaction so reset leaves the bus fully quiet.
  assign apb.psel    = (state_q == StSetup) || (state_q == StAccess);
  assign apb.penable = (state_q == StAccess);
  assign apb.paddr   = apb.psel ? addr : '0;
  assign apb.pwrite  = 1'b0;
  assign apb.pstrb   = '0;
  assign apb.pwdata  = '0;

  assign valid_o    = (state_q == StPush);
  assign last_o     = valid_o && last_line;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StFinish);
  assign data_o     = data_q;
  assign line_o     = beat_line_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_line_o = err_line_q;

endmodule
